// File: rtl/rsdsa_pkg.sv
// rtl/rsdsa_pkg.sv - shared RAM slots, ALU opcodes and step record for the ECDSA sequencers
package rsdsa_pkg;

    // Scratch RAM slot map
    localparam logic [4:0] K_INV  = 5'd12;
    localparam logic [4:0] R_NUM  = 5'd13;
    localparam logic [4:0] S_NUM  = 5'd14;
    localparam logic [4:0] X_KG   = 5'd15;
    localparam logic [4:0] HASH   = 5'd16;
    localparam logic [4:0] PRKEY  = 5'd17;
    localparam logic [4:0] ZRRAM  = 5'd18;
    localparam logic [4:0] ONERAM = 5'd19;
    localparam logic [4:0] K_NUM  = 5'd20;
    localparam logic [4:0] S_RP   = 5'd29;
    localparam logic [4:0] S_RPH  = 5'd30;
    localparam logic [4:0] BLNK   = 5'd31;

    // Shared ALU opcodes
    typedef enum logic [1:0] {
        FA  = 2'b00,
        MUL = 2'b01,
        INV = 2'b10
    } alu_op_e;

    // One arithmetic step: dst <= op(srcA, srcB)
    typedef struct packed {
        alu_op_e    op;
        logic [4:0] src_a;
        logic [4:0] src_b;
        logic [4:0] dst;
    } step_rec_t;

endpackage

// File: rtl/rsstep_rom.sv
// rtl/rsstep_rom.sv - step index to (op, A, B, dst) map for the signature sequence
module rsstep_rom
    import rsdsa_pkg::*;
(
    input  logic [1:0] i_step,
    output step_rec_t  o_rec
);

    // r = x_kG + 0, then s = (r*priv + hash) * k^-1
    always_comb begin
        o_rec = '{op: FA, src_a: X_KG, src_b: ZRRAM, dst: R_NUM};
        case (i_step)
            2'd0: o_rec = '{op: FA,  src_a: X_KG,  src_b: ZRRAM, dst: R_NUM};
            2'd1: o_rec = '{op: MUL, src_a: R_NUM, src_b: PRKEY, dst: S_RP};
            2'd2: o_rec = '{op: FA,  src_a: S_RP,  src_b: HASH,  dst: S_RPH};
            2'd3: o_rec = '{op: MUL, src_a: S_RPH, src_b: K_INV, dst: S_NUM};
            default: o_rec = '{op: FA, src_a: X_KG, src_b: ZRRAM, dst: R_NUM};
        endcase
    end

endmodule

// File: rtl/rssign_seq.sv
// rtl/rssign_seq.sv - sequences the shared ALU through r and s of the ECDSA signature
module rssign_seq
    import rsdsa_pkg::*;
#(
    parameter int WID  = 256,
    parameter int AWID = 5,
    parameter int TOUT = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rzero,
    output logic            szero,
    output logic            tout,
    output logic [AWID-1:0] ramra,
    output logic [AWID-1:0] ramwa,
    output logic [WID-1:0]  ramwd,
    output logic            ramwe,
    output logic            aen,
    output logic [1:0]      aop,
    input  logic [WID-1:0]  adi,
    input  logic            adivld
);

    typedef enum logic [2:0] {IDLE, LDA, LDB, WAIT, NEXT} state_e;

    state_e          r_state, w_state;
    logic [1:0]      r_step, w_step;
    logic [15:0]     r_wdog, w_wdog;
    logic            r_zres, w_zres;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_rzero, w_rzero;
    logic            r_szero, w_szero;
    logic            r_tout, w_tout;
    logic [AWID-1:0] r_ramra, w_ramra;
    logic [AWID-1:0] r_ramwa, w_ramwa;
    logic [WID-1:0]  r_ramwd, w_ramwd;
    logic            r_ramwe, w_ramwe;
    logic            r_aen, w_aen;
    alu_op_e         r_aop, w_aop;
    step_rec_t       w_rec;

    rsstep_rom u_rom (
        .i_step (r_step),
        .o_rec  (w_rec)
    );

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state = r_state;
        w_step  = r_step;
        w_wdog  = r_wdog;
        w_zres  = r_zres;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_rzero = r_rzero;
        w_szero = r_szero;
        w_tout  = r_tout;
        w_ramra = AWID'(ZRRAM);
        w_ramwa = AWID'(BLNK);
        w_ramwd = r_ramwd;
        w_ramwe = 1'b0;
        w_aen   = 1'b0;
        w_aop   = r_aop;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_rzero = 1'b0;
                    w_szero = 1'b0;
                    w_tout  = 1'b0;
                    w_step  = 2'd0;
                    w_busy  = 1'b1;
                    w_state = LDA;
                end
            end
            LDA: begin
                w_ramra = AWID'(w_rec.src_a);
                w_aop   = w_rec.op;
                w_state = LDB;
            end
            LDB: begin
                w_ramra = AWID'(w_rec.src_b);
                w_aen   = 1'b1;
                w_wdog  = 16'd0;
                w_state = WAIT;
            end
            WAIT: begin
                if (adivld) begin
                    w_ramwe = 1'b1;
                    w_ramwa = AWID'(w_rec.dst);
                    w_ramwd = adi;
                    w_zres  = (adi == '0);
                    w_state = NEXT;
                end else if (r_wdog == 16'(TOUT - 1)) begin
                    // ALU never answered: abort without writing anything
                    w_tout  = 1'b1;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_wdog  = r_wdog + 16'd1;
                    w_ramra = r_ramra;
                end
            end
            NEXT: begin
                if (r_step == 2'd0 && r_zres) begin
                    w_rzero = 1'b1;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else if (r_step == 2'd3) begin
                    w_szero = r_zres;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_step  = r_step + 2'd1;
                    w_state = LDA;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= 2'd0;
            r_wdog  <= 16'd0;
            r_zres  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rzero <= 1'b0;
            r_szero <= 1'b0;
            r_tout  <= 1'b0;
            r_ramra <= AWID'(ZRRAM);
            r_ramwa <= AWID'(BLNK);
            r_ramwd <= '0;
            r_ramwe <= 1'b0;
            r_aen   <= 1'b0;
            r_aop   <= FA;
        end else begin
            r_state <= w_state;
            r_step  <= w_step;
            r_wdog  <= w_wdog;
            r_zres  <= w_zres;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_rzero <= w_rzero;
            r_szero <= w_szero;
            r_tout  <= w_tout;
            r_ramra <= w_ramra;
            r_ramwa <= w_ramwa;
            r_ramwd <= w_ramwd;
            r_ramwe <= w_ramwe;
            r_aen   <= w_aen;
            r_aop   <= w_aop;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign rzero = r_rzero;
    assign szero = r_szero;
    assign tout  = r_tout;
    assign ramra = r_ramra;
    assign ramwa = r_ramwa;
    assign ramwd = r_ramwd;
    assign ramwe = r_ramwe;
    assign aen   = r_aen;
    assign aop   = r_aop;

endmodule
